// File: rtl/memwr_uart_monitor.sv
// memwr_uart_monitor: queues every {address,data} change from the datapath and streams it as a 7-byte 8N1 UART frame.
// Define MEMWR_MON_ADDR_FILTER_EN to queue only changes whose address lies within ADDR_LO..ADDR_HI.
module memwr_uart_monitor #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         DEPTH        = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter logic [8:0] ADDR_LO      = 9'd0,
    parameter logic [8:0] ADDR_HI      = 9'd511
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [8:0]               extmemaddress,
    input  logic [31:0]              extmemdata,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
`ifdef MEMWR_MON_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state;
    logic [40:0]   mem [DEPTH];
    logic [40:0]   prev, frame, cur;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [BW-1:0] baud;
    logic [2:0]    byte_idx, bit_idx;
    logic [55:0]   frame_bytes;
    logic [7:0]    cur_byte;
    logic          change, in_range, qualify, full, pop, push, baud_done;
    always_comb begin
        cur         = {extmemaddress, extmemdata};
        change      = enable && (cur != prev);
        in_range    = !FILTER_EN || (extmemaddress >= ADDR_LO && extmemaddress <= ADDR_HI);
        qualify     = change && in_range;
        full        = fifo_count == FULL_CNT;
        pop         = (state == IDLE) && (fifo_count != '0);
        push        = qualify && (!full || pop);
        baud_done   = baud == BW'(CLKS_PER_BIT - 1);
        frame_bytes = {SYNC_BYTE, 7'b0, frame};
        cur_byte    = 8'(frame_bytes >> {3'd6 - byte_idx, 3'b000});
        busy        = (state != IDLE) || (fifo_count != '0);
    end
    // prev follows every enabled change, even when the entry is filtered or dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (change) prev <= cur;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (qualify && full && !pop) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cur;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            frame    <= '0;
            baud     <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    frame    <= mem[rd_ptr];
                    byte_idx <= '0;
                    baud     <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: if (baud_done) begin
                    baud    <= '0;
                    bit_idx <= '0;
                    tx      <= cur_byte[0];
                    state   <= DATA;
                end else baud <= baud + 1'b1;
                DATA: if (baud_done) begin
                    baud <= '0;
                    if (bit_idx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx      <= cur_byte[bit_idx + 3'd1];
                    end
                end else baud <= baud + 1'b1;
                STOP: if (baud_done) begin
                    baud <= '0;
                    if (byte_idx != 3'd6) begin
                        byte_idx <= byte_idx + 3'd1;
                        tx       <= 1'b0;
                        state    <= START;
                    end else state <= IDLE;
                end else baud <= baud + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memwr_uart_monitor.sv
// tb_memwr_uart_monitor: scoreboard bench, expected frame bytes queued at stimulus time, popped by a UART receiver model.
module tb_memwr_uart_monitor;
    logic        clk = 1'b0, reset = 1'b1, enable = 1'b1;
    logic [8:0]  addr = '0;
    logic [31:0] data = '0;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_count;
    int          total = 0, bad = 0;
    logic [7:0]  exp_q [$];
    int          rx_n = 0, rx_cnt = 0;
    bit          rx_act = 1'b0;
    logic [7:0]  rx_byte = '0;
    int          n, low, bsy, nz, rn;
    logic [8:0]  a_arr [6];
    logic [31:0] d_arr [6];

    always #5 clk = ~clk;

    memwr_uart_monitor #(.CLKS_PER_BIT(4), .DEPTH(4), .SYNC_BYTE(8'hA5),
                         .ADDR_LO(9'h100), .ADDR_HI(9'h1FF)) dut (
        .clk(clk), .reset(reset), .enable(enable), .extmemaddress(addr),
        .extmemdata(data), .tx(tx), .busy(busy), .overflow(overflow),
        .fifo_count(fifo_count));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input logic [8:0] a, input logic [31:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back({7'b0, a[8]});
        exp_q.push_back(a[7:0]);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endfunction

    // bits sampled mid-bit: 4 clocks per bit, start edge seen at rx_cnt 0
    always @(negedge clk) begin
        if (reset) begin
            rx_act = 1'b0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && rx_cnt % 4 == 2) rx_byte = {tx, rx_byte[7:1]};
            if (rx_cnt == 38) begin
                check("stop_bit", tx, 1);
                rx_n++;
                if (exp_q.size() == 0) check("rx_unexpected", rx_byte, 64'h1FF);
                else check("rx_byte", rx_byte, exp_q.pop_front());
                rx_act = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            if (busy) cnt++;
        end while (busy && cnt < max);
        check("idle_timeout", cnt < max, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", fifo_count, 0);
        @(negedge clk);
        reset = 1'b0;
        low = 0; bsy = 0; nz = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) low++;
            if (busy !== 1'b0) bsy++;
            if (fifo_count !== 3'd0) nz++;
        end
        check("zero_tx_low", low, 0);
        check("zero_busy", bsy, 0);
        check("zero_count", nz, 0);

        addr = 9'h104; data = 32'hDEADBEEF;
        push_frame(addr, data);
        wait_idle(600, n);
        check("single_busy_len", n, 281);
        check("single_rx_n", rx_n, 7);
        check("single_q_empty", exp_q.size(), 0);
        check("single_overflow", overflow, 0);

        for (int i = 0; i < 6; i++) begin
            a_arr[i] = 9'h1C0 + 9'(i);
            d_arr[i] = $urandom;
            addr = a_arr[i]; data = d_arr[i];
            if (i < 5) push_frame(a_arr[i], d_arr[i]);
            @(negedge clk);
        end
        check("burst_count", fifo_count, 4);
        check("burst_overflow", overflow, 1);
        wait_idle(2000, n);
        check("burst_rx_n", rx_n, 42);
        check("burst_q_empty", exp_q.size(), 0);

        enable = 1'b0; nz = 0;
        repeat (50) begin
            addr = 9'($urandom); data = $urandom;
            @(negedge clk);
            if (fifo_count !== 3'd0 || busy !== 1'b0) nz++;
        end
        check("disabled_queued", nz, 0);
        addr = a_arr[5]; data = d_arr[5];
        @(negedge clk);
        enable = 1'b1; nz = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_count !== 3'd0 || busy !== 1'b0) nz++;
        end
        check("reenable_queued", nz, 0);
        check("reenable_rx_n", rx_n, 42);

        for (int i = 0; i < 3; i++) begin
            addr = 9'h010 + 9'(i); data = $urandom;
            push_frame(addr, data);
            @(negedge clk);
        end
        repeat (98) @(negedge clk);
        check("pre_reset_count", fifo_count, 2);
        reset = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rx_n", rx_n, 44);
        exp_q.delete();
        rn = rx_n;
        addr = '0; data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        low = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) low++;
        end
        check("postrst_tx_low", low, 0);
        check("postrst_rx_n", rx_n, rn);
        check("postrst_count", fifo_count, 0);

        addr = 9'h0FF; data = 32'h12345678;
`ifndef MEMWR_MON_ADDR_FILTER_EN
        push_frame(addr, data);
`endif
        wait_idle(600, n);
`ifdef MEMWR_MON_ADDR_FILTER_EN
        check("filter_below", n, 0);
`else
        check("filter_below", n, 281);
`endif
        addr = 9'h100; data = 32'hCAFEF00D;
        push_frame(addr, data);
        wait_idle(600, n);
        check("filter_edge_len", n, 281);
        check("filter_q_empty", exp_q.size(), 0);
        check("final_overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
